// File: rtl/guess_judge_if.sv
// Handshake and display bundle between the game controller and the guess judge.
// The master drives start/target/guess; the judge (slave) returns state, hint and segment codes.
interface guess_judge_if #(
    parameter int WIDTH     = 5,
    parameter int MAX_TRIES = 3,
    parameter int TW        = $clog2(MAX_TRIES + 1)
);
    logic             start;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] guess;
    logic             guess_valid;
    logic [1:0]       state;
    logic [TW-1:0]    tries_left;
    logic [1:0]       hint;
    logic             reject;
    logic             flag;
    logic             win;
    logic             lose;
    logic [7:0]       HEX5g;
    logic [7:0]       HEX4g;

    modport master (
        output start, target, guess, guess_valid,
        input  state, tries_left, hint, reject, flag, win, lose, HEX5g, HEX4g
    );

    modport slave (
        input  start, target, guess, guess_valid,
        output state, tries_left, hint, reject, flag, win, lose, HEX5g, HEX4g
    );
endinterface

// File: rtl/guess_judge.sv
// Registered guess-evaluation engine: scores guesses against a latched target,
// narrows the legal window after each miss and drives the two hint digits.
module guess_judge #(
    parameter int WIDTH     = 5,
    parameter int MAX_TRIES = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    guess_judge_if.slave bus
);
    localparam int TW = $clog2(MAX_TRIES + 1);

    localparam logic [7:0] SEG_H     = 8'b10001001;
    localparam logic [7:0] SEG_I     = 8'b11001111;
    localparam logic [7:0] SEG_L     = 8'b11000111;
    localparam logic [7:0] SEG_O     = 8'b10100011;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_EQ    = 8'b10110111;
    localparam logic [7:0] SEG_DASH  = 8'b10111111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PLAY = 2'b01,
        WIN  = 2'b10,
        LOSE = 2'b11
    } state_t;

    state_t           st;
    logic [WIDTH-1:0] tgt;
    logic [WIDTH-1:0] lo_b;
    logic [WIDTH-1:0] hi_b;
    logic [TW-1:0]    tries;
    logic [1:0]       hint_r;
    logic             rej;
    logic [7:0]       hex5;
    logic [7:0]       hex4;

    // start has priority over guess_valid; a guess outside [lo_b, hi_b] only pulses reject.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st     <= IDLE;
            tgt    <= '0;
            lo_b   <= '0;
            hi_b   <= '1;
            tries  <= '0;
            hint_r <= 2'b00;
            rej    <= 1'b0;
            hex5   <= SEG_BLANK;
            hex4   <= SEG_BLANK;
        end else begin
            rej <= 1'b0;
            if (bus.start) begin
                st     <= PLAY;
                tgt    <= bus.target;
                lo_b   <= '0;
                hi_b   <= '1;
                tries  <= TW'(MAX_TRIES);
                hint_r <= 2'b00;
                hex5   <= SEG_BLANK;
                hex4   <= SEG_BLANK;
            end else if (bus.guess_valid && st == PLAY) begin
                if (bus.guess < lo_b || bus.guess > hi_b) begin
                    rej <= 1'b1;
                end else begin
                    tries <= tries - TW'(1);
                    if (bus.guess == tgt) begin
                        st     <= WIN;
                        hint_r <= 2'b11;
                        hex5   <= SEG_EQ;
                        hex4   <= SEG_EQ;
                    end else begin
                        if (bus.guess < tgt) begin
                            hint_r <= 2'b01;
                            lo_b   <= bus.guess + WIDTH'(1);
                            hex5   <= SEG_L;
                            hex4   <= SEG_O;
                        end else begin
                            hint_r <= 2'b10;
                            hi_b   <= bus.guess - WIDTH'(1);
                            hex5   <= SEG_H;
                            hex4   <= SEG_I;
                        end
                        // Last try missed: the dash display overrides the direction digits.
                        if (tries == TW'(1)) begin
                            st   <= LOSE;
                            hex5 <= SEG_DASH;
                            hex4 <= SEG_DASH;
                        end
                    end
                end
            end
        end
    end

    assign bus.state      = st;
    assign bus.tries_left = tries;
    assign bus.hint       = hint_r;
    assign bus.reject     = rej;
    assign bus.flag       = (st == WIN) || (st == LOSE);
    assign bus.win        = (st == WIN);
    assign bus.lose       = (st == LOSE);
    assign bus.HEX5g      = hex5;
    assign bus.HEX4g      = hex4;
endmodule

// File: tb/tb_guess_judge.sv
// Bench for guess_judge: two instances (5-bit/3 tries and 8-bit/6 tries) share directed
// stimulus and are compared every cycle against a rule-level model, plus literal spot checks.
module tb_guess_judge;
    localparam logic [7:0] H_C  = 8'b10001001;
    localparam logic [7:0] I_C  = 8'b11001111;
    localparam logic [7:0] L_C  = 8'b11000111;
    localparam logic [7:0] O_C  = 8'b10100011;
    localparam logic [7:0] BL_C = 8'hFF;
    localparam logic [7:0] EQ_C = 8'b10110111;
    localparam logic [7:0] DS_C = 8'b10111111;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] target;
    logic       guess_valid;
    logic [7:0] guess;
    bit         cmpOn;
    int         checks;
    int         errors;

    guess_judge_if #(.WIDTH(5), .MAX_TRIES(3)) busA ();
    guess_judge_if #(.WIDTH(8), .MAX_TRIES(6)) busB ();

    assign busA.start       = start;
    assign busA.target      = target[4:0];
    assign busA.guess       = guess[4:0];
    assign busA.guess_valid = guess_valid;
    assign busB.start       = start;
    assign busB.target      = target;
    assign busB.guess       = guess;
    assign busB.guess_valid = guess_valid;

    guess_judge #(.WIDTH(5), .MAX_TRIES(3)) dutA (.clk(clk), .rst_n(rst_n), .bus(busA));
    guess_judge #(.WIDTH(8), .MAX_TRIES(6)) dutB (.clk(clk), .rst_n(rst_n), .bus(busB));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int st;
        int tgt;
        int tries;
        int lo;
        int hi;
        int hint;
        int rej;
        int h5;
        int h4;
    } mdl_t;

    function automatic mdl_t mreset(int w);
        mdl_t n;
        n.st = 0; n.tgt = 0; n.tries = 0; n.lo = 0; n.hi = (1 << w) - 1;
        n.hint = 0; n.rej = 0; n.h5 = 255; n.h4 = 255;
        return n;
    endfunction

    // Game rules stated directly: window check, scoring, tries and display per state.
    function automatic mdl_t mstep(mdl_t m, bit s, int t, bit v, int g, int maxT, int w);
        mdl_t n;
        int top;
        int gg;
        n = m;
        n.rej = 0;
        top = (1 << w) - 1;
        gg = g & top;
        if (s) begin
            n.st = 1; n.tgt = t & top; n.tries = maxT; n.lo = 0; n.hi = top;
            n.hint = 0; n.h5 = 255; n.h4 = 255;
        end else if (v && m.st == 1) begin
            if (gg < m.lo || gg > m.hi) begin
                n.rej = 1;
            end else begin
                n.tries = m.tries - 1;
                if (gg == m.tgt) begin
                    n.hint = 3; n.st = 2; n.h5 = EQ_C; n.h4 = EQ_C;
                end else begin
                    if (gg < m.tgt) begin
                        n.hint = 1; n.lo = gg + 1; n.h5 = L_C; n.h4 = O_C;
                    end else begin
                        n.hint = 2; n.hi = gg - 1; n.h5 = H_C; n.h4 = I_C;
                    end
                    if (n.tries == 0) begin
                        n.st = 3; n.h5 = DS_C; n.h4 = DS_C;
                    end
                end
            end
        end
        return n;
    endfunction

    mdl_t mA;
    mdl_t mB;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mA <= mreset(5);
            mB <= mreset(8);
        end else begin
            mA <= mstep(mA, start, int'(target), guess_valid, int'(guess), 3, 5);
            mB <= mstep(mB, start, int'(target), guess_valid, int'(guess), 6, 8);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compareDut(input string tag, input mdl_t m,
                              input logic [1:0] st, input logic [7:0] tries,
                              input logic [1:0] hintVal, input logic rej, input logic flag,
                              input logic win, input logic lose,
                              input logic [7:0] h5, input logic [7:0] h4);
        checkOutput({tag, ".state"}, 32'(st), m.st);
        checkOutput({tag, ".tries_left"}, 32'(tries), m.tries);
        checkOutput({tag, ".hint"}, 32'(hintVal), m.hint);
        checkOutput({tag, ".reject"}, 32'(rej), m.rej);
        checkOutput({tag, ".flag"}, 32'(flag), (m.st >= 2) ? 1 : 0);
        checkOutput({tag, ".win"}, 32'(win), (m.st == 2) ? 1 : 0);
        checkOutput({tag, ".lose"}, 32'(lose), (m.st == 3) ? 1 : 0);
        checkOutput({tag, ".HEX5g"}, 32'(h5), m.h5);
        checkOutput({tag, ".HEX4g"}, 32'(h4), m.h4);
    endtask

    always @(negedge clk) begin
        if (cmpOn) begin
            compareDut("A", mA, busA.state, 8'(busA.tries_left), busA.hint, busA.reject,
                       busA.flag, busA.win, busA.lose, busA.HEX5g, busA.HEX4g);
            compareDut("B", mB, busB.state, 8'(busB.tries_left), busB.hint, busB.reject,
                       busB.flag, busB.win, busB.lose, busB.HEX5g, busB.HEX4g);
        end
    end

    task automatic applyStimulus(input bit s, input int t, input bit v, input int g);
        @(negedge clk);
        start       = s;
        target      = 8'(t);
        guess_valid = v;
        guess       = 8'(g);
    endtask

    task automatic idle();
        applyStimulus(1'b0, 0, 1'b0, 0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cmpOn = 1'b0;
        rst_n = 1'b0;
        start = 1'b0;
        target = '0;
        guess_valid = 1'b0;
        guess = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        cmpOn = 1'b1;

        idle();
        checkOutput("rst.state", 32'(busA.state), 0);
        checkOutput("rst.tries", 32'(busA.tries_left), 0);
        checkOutput("rst.hex5", 32'(busA.HEX5g), 32'hFF);
        checkOutput("rst.flag", 32'(busA.flag), 0);

        applyStimulus(1'b1, 13, 1'b0, 0);
        idle();
        checkOutput("start.state", 32'(busA.state), 1);
        checkOutput("start.tries", 32'(busA.tries_left), 3);
        checkOutput("start.hex4", 32'(busA.HEX4g), 32'hFF);
        checkOutput("start.flag", 32'(busA.flag), 0);

        applyStimulus(1'b0, 0, 1'b1, 20);
        idle();
        checkOutput("high.hint", 32'(busA.hint), 2);
        checkOutput("high.hex5", 32'(busA.HEX5g), 32'b10001001);
        checkOutput("high.hex4", 32'(busA.HEX4g), 32'b11001111);
        checkOutput("high.tries", 32'(busA.tries_left), 2);

        applyStimulus(1'b0, 0, 1'b1, 25);
        idle();
        checkOutput("rej.reject", 32'(busA.reject), 1);
        checkOutput("rej.tries", 32'(busA.tries_left), 2);
        checkOutput("rej.hint", 32'(busA.hint), 2);
        idle();
        checkOutput("rej.pulse_end", 32'(busA.reject), 0);

        // Restart from PLAY, then 5 / 20 / 30 (out of window) / 13.
        applyStimulus(1'b1, 13, 1'b0, 0);
        applyStimulus(1'b0, 0, 1'b1, 5);
        applyStimulus(1'b0, 0, 1'b1, 20);
        applyStimulus(1'b0, 0, 1'b1, 30);
        applyStimulus(1'b0, 0, 1'b1, 13);
        idle();
        checkOutput("win.state", 32'(busA.state), 2);
        checkOutput("win.win", 32'(busA.win), 1);
        checkOutput("win.flag", 32'(busA.flag), 1);
        checkOutput("win.hint", 32'(busA.hint), 3);
        checkOutput("win.hex5", 32'(busA.HEX5g), 32'b10110111);
        checkOutput("win.hex4", 32'(busA.HEX4g), 32'b10110111);
        checkOutput("win.tries", 32'(busA.tries_left), 0);
        checkOutput("winB.state", 32'(busB.state), 2);
        checkOutput("winB.tries", 32'(busB.tries_left), 3);

        applyStimulus(1'b1, 13, 1'b0, 0);
        applyStimulus(1'b0, 0, 1'b1, 1);
        applyStimulus(1'b0, 0, 1'b1, 2);
        applyStimulus(1'b0, 0, 1'b1, 3);
        idle();
        checkOutput("lose.state", 32'(busA.state), 3);
        checkOutput("lose.lose", 32'(busA.lose), 1);
        checkOutput("lose.hint", 32'(busA.hint), 1);
        checkOutput("lose.hex5", 32'(busA.HEX5g), 32'b10111111);
        checkOutput("lose.hex4", 32'(busA.HEX4g), 32'b10111111);
        checkOutput("loseB.state", 32'(busB.state), 1);
        checkOutput("loseB.hex5", 32'(busB.HEX5g), 32'b11000111);
        checkOutput("loseB.hex4", 32'(busB.HEX4g), 32'b10100011);
        applyStimulus(1'b0, 0, 1'b1, 13);
        idle();
        checkOutput("lose.hold_state", 32'(busA.state), 3);
        checkOutput("lose.hold_tries", 32'(busA.tries_left), 0);
        checkOutput("loseB.late_win", 32'(busB.state), 2);

        applyStimulus(1'b1, 7, 1'b1, 7);
        idle();
        checkOutput("both.state", 32'(busA.state), 1);
        checkOutput("both.tries", 32'(busA.tries_left), 3);
        checkOutput("both.hint", 32'(busA.hint), 0);

        // Held guess_valid: 20 sets hi_b=19, 19 accepted (hi_b=18), repeated 19 rejected.
        applyStimulus(1'b0, 0, 1'b1, 20);
        applyStimulus(1'b0, 0, 1'b1, 19);
        applyStimulus(1'b0, 0, 1'b1, 19);
        idle();
        checkOutput("b2b.reject", 32'(busA.reject), 1);
        checkOutput("b2b.tries", 32'(busA.tries_left), 1);
        checkOutput("b2b.hint", 32'(busA.hint), 2);

        applyStimulus(1'b1, 31, 1'b0, 0);
        applyStimulus(1'b0, 0, 1'b1, 0);
        applyStimulus(1'b0, 0, 1'b1, 0);
        idle();
        checkOutput("edge.lo_reject", 32'(busA.reject), 1);
        checkOutput("edge.tries", 32'(busA.tries_left), 2);
        applyStimulus(1'b0, 0, 1'b1, 31);
        idle();
        checkOutput("edge.win_top", 32'(busA.state), 2);
        checkOutput("edge.tries_after", 32'(busA.tries_left), 1);

        applyStimulus(1'b1, 13, 1'b0, 0);
        applyStimulus(1'b0, 0, 1'b1, 20);
        idle();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst.state", 32'(busA.state), 0);
        checkOutput("arst.tries", 32'(busA.tries_left), 0);
        checkOutput("arst.hint", 32'(busA.hint), 0);
        checkOutput("arst.hex5", 32'(busA.HEX5g), 32'hFF);
        checkOutput("arst.hex4", 32'(busA.HEX4g), 32'hFF);
        checkOutput("arstB.state", 32'(busB.state), 0);
        checkOutput("arstB.hint", 32'(busB.hint), 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        idle();
        cmpOn = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
